// File: rtl/riscv_fetch.sv
// Instruction fetch: PC + sync-read instruction memory + prefetch FIFO feeding the core.
// Latency: 2 edges from PC issue to instr_valid; 1 instr/cycle sustained while instr_ready=1.
// Backpressure: credit check (fifo level + in-flight read) stops issue before the FIFO can overflow.
//
// Ports:
//   clk, rst (async active-low)      clock and reset
//   prog_we/prog_addr/prog_data      instruction memory write port (word index)
//   redirect_valid/redirect_pc       load new PC, flush FIFO and in-flight read
//   instr_valid/instr_ready          handshake on the FIFO head
//   instr/instr_pc                   head instruction and its byte PC (0 when empty)
//   fifo_level                       number of occupied FIFO entries
module riscv_fetch #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          prog_we,
   input  logic [$clog2(DEPTH)-1:0]      prog_addr,
   input  logic [WIDTH-1:0]              prog_data,
   input  logic                          redirect_valid,
   input  logic [WIDTH-1:0]              redirect_pc,
   input  logic                          instr_ready,
   output logic                          instr_valid,
   output logic [WIDTH-1:0]              instr,
   output logic [WIDTH-1:0]              instr_pc,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] fifo_ins [FIFO_DEPTH];
   logic [WIDTH-1:0] fifo_pc  [FIFO_DEPTH];

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] rd_pc_q;
   logic [WIDTH-1:0] rd_dat_q;
   logic             inflight_q;
   logic [FW-1:0]    wr_ptr_q;
   logic [FW-1:0]    rd_ptr_q;
   logic [FW:0]      cnt_q;

   logic             issue;
   logic             push;
   logic             pop;
   logic [FW+1:0]    credit_used;

   // An in-flight read already owns a FIFO slot, so count it against capacity.
   assign credit_used = {1'b0, cnt_q} + {{(FW+1){1'b0}}, inflight_q};
   assign issue       = rst & ~redirect_valid & (credit_used < (FW+2)'(FIFO_DEPTH));
   assign push        = inflight_q & ~redirect_valid;
   assign pop         = instr_valid & instr_ready & ~redirect_valid;

   // Memory is not reset. Both statements are non-blocking, so a same-edge
   // write to the word being read returns the old contents (read-first).
   always_ff @(posedge clk) begin
      if (issue) begin
         rd_dat_q <= mem[pc_q[AW+1:2]];
      end
      if (prog_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // FIFO payload storage needs no reset: outputs are gated by the level.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_ins[wr_ptr_q] <= rd_dat_q;
         fifo_pc[wr_ptr_q]  <= rd_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= '0;
         rd_pc_q    <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else if (redirect_valid) begin
         // Redirect wins: drop FIFO contents and any read still in flight.
         pc_q       <= redirect_pc & ~(WIDTH'(3));
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q    <= pc_q + WIDTH'(4);
            rd_pc_q <= pc_q;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + FW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (FW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (FW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign instr_valid = (cnt_q != '0);
   assign instr       = instr_valid ? fifo_ins[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q]  : '0;
   assign fifo_level  = cnt_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch (DEPTH=16 so PC wrap is reachable).
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Prints one summary line: CHECKS <n> ERRORS <n>.
module tb_riscv_fetch;

   logic        clk;
   logic        rst;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [31:0] prog_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [31:0] words [16];

   riscv_fetch #(.WIDTH(32), .DEPTH(16), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .prog_we        (prog_we),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_ready    (instr_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fifo_level     (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   // Watchdog: the sequence below is a fixed number of edges, so this only fires on a stuck sim.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      words[0]  = 32'h00A08093; words[1]  = 32'h00A10113;
      words[2]  = 32'h001101B3; words[3]  = 32'h0030A233;
      words[4]  = 32'h00115293; words[5]  = 32'h00211313;
      words[6]  = 32'h0032F3B3; words[7]  = 32'h0032E433;
      words[8]  = 32'h0032C4B3; words[9]  = 32'h40610533;
      words[10] = 32'h004155B3; words[11] = 32'h00411633;
      for (int i = 12; i < 16; i++) words[i] = 32'h1000_0000 + 32'(i);

      rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

      // Load memory while in reset (memory ignores reset).
      #2;
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1; prog_addr = 4'(i); prog_data = words[i];
         tick();
      end
      prog_we = 1'b0;

      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_pcq", dut.pc_q, 32'd0);

      // Stream: 2-edge latency, then one word per cycle.
      instr_ready = 1'b1;
      rst = 1'b1;
      tick();
      chk("e1_valid", 32'(instr_valid), 32'd0);
      tick();
      for (int i = 0; i < 12; i++) begin
         chk("str_valid", 32'(instr_valid), 32'd1);
         chk("str_pc", instr_pc, 32'(i * 4));
         chk("str_instr", instr, words[i]);
         tick();
      end

      // Reset between edges while streaming.
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(instr_valid), 32'd0);
      chk("mrst_level", 32'(fifo_level), 32'd0);
      chk("mrst_instr", instr, 32'd0);
      chk("mrst_pc", instr_pc, 32'd0);
      tick();
      tick();

      // Restart from PC 0 with ready low: backpressure fill.
      instr_ready = 1'b0;
      rst = 1'b1;
      tick();
      chk("rs_e1_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("rs_e2_valid", 32'(instr_valid), 32'd1);
      chk("rs_e2_pc", instr_pc, 32'd0);
      for (int i = 0; i < 8; i++) tick();
      chk("bp_level", 32'(fifo_level), 32'd4);
      chk("bp_pcq", dut.pc_q, 32'h10);
      chk("bp_instr", instr, words[0]);
      chk("bp_pc", instr_pc, 32'd0);

      // Resume: no bubble.
      instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("res_valid", 32'(instr_valid), 32'd1);
         chk("res_pc", instr_pc, 32'(i * 4));
         tick();
      end

      // Redirect with a full FIFO.
      instr_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("full_level", 32'(fifo_level), 32'd4);
      redirect(32'h20);
      chk("rd_r_valid", 32'(instr_valid), 32'd0);
      chk("rd_r_level", 32'(fifo_level), 32'd0);
      tick();
      chk("rd_r1_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("rd_r2_valid", 32'(instr_valid), 32'd1);
      chk("rd_r2_pc", instr_pc, 32'h20);
      chk("rd_r2_instr", instr, words[8]);

      // Misaligned redirect.
      instr_ready = 1'b1;
      redirect(32'h0A);
      tick();
      tick();
      chk("mis_pc", instr_pc, 32'h08);
      chk("mis_instr", instr, words[2]);

      // Wrap past the end of a 16-word memory.
      redirect(32'h3C);
      tick();
      tick();
      chk("wrap0_pc", instr_pc, 32'h3C);
      chk("wrap0_instr", instr, words[15]);
      tick();
      chk("wrap1_pc", instr_pc, 32'h40);
      chk("wrap1_instr", instr, words[0]);

      // Same-edge write and read of word 1: old data returned.
      redirect(32'h00);
      tick();                       // issues PC 0
      prog_we = 1'b1; prog_addr = 4'd1; prog_data = 32'hDEADBEEF;
      tick();                       // issues PC 4 and writes word 1
      prog_we = 1'b0;
      chk("rw0_pc", instr_pc, 32'h00);
      chk("rw0_instr", instr, words[0]);
      tick();
      chk("rw1_pc", instr_pc, 32'h04);
      chk("rw1_instr", instr, 32'h00A10113);
      redirect(32'h04);
      tick();
      tick();
      chk("rw2_pc", instr_pc, 32'h04);
      chk("rw2_instr", instr, 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
